// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int PC_W_DEF  = 10;  // PC / redirect address width
    localparam int REG_W_DEF = 5;   // register specifier width
    localparam int CNT_W     = 4;   // boot/stall down-counter width
    localparam int PERF_W    = 16;  // performance counter width

endpackage

// File: rtl/fetch_sequencer_load_use.sv
// Load-use hazard compare: a load in EX whose destination feeds either
// source of the instruction in ID. Register 0 never creates a hazard.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    output logic             o_hazard
);

    logic w_nonzero;
    logic w_match;

    assign w_nonzero = (i_ex_rt != '0);
    assign w_match   = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
    assign o_hazard  = i_ex_memread && w_nonzero && w_match;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control for the 5-stage pipeline: boot hold, load-use stalls,
// branch/jump redirects and halt/resume. Define FETCH_SEQ_PERF_EN to build
// the stall/flush performance counters; otherwise those ports read 0.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int REG_W       = REG_W_DEF,
    parameter int BOOT_CYCLES = 4,
    parameter int LOAD_STALL  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              jump_id,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              halt_id,
    input  logic              resume,
    output logic              pc_write,
    output logic              writeIFID,
    output logic              PCSrc,
    output logic [PC_W-1:0]   PCJump,
    output logic              jump,
    output logic [PC_W-1:0]   jumpAdd,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              halted,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count
);

    // BOOT lasts BOOT_CYCLES cycles; STALL lasts LOAD_STALL-1 cycles after
    // the hazard cycle itself, which is spent in RUN.
    localparam logic [CNT_W-1:0] BOOT_INIT  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);
    localparam bit               MULTI_STALL = (LOAD_STALL > 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hazard;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_ex_memread (ex_memread),
        .i_ex_rt      (ex_rt),
        .o_hazard     (w_hazard)
    );

    // Redirect addresses pass straight through; only the selects are gated
    assign PCJump  = branch_target;
    assign jumpAdd = jump_target;

    // State and down-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_cnt   <= BOOT_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: branch beats load-use beats jump beats halt in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            BOOT: begin
                if (r_cnt == '0) w_state_nxt = RUN;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            RUN: begin
                if (branch_taken) begin
                    w_state_nxt = RUN;
                end else if (w_hazard) begin
                    if (MULTI_STALL) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = STALL_INIT;
                    end
                end else if (jump_id) begin
                    w_state_nxt = RUN;
                end else if (halt_id) begin
                    w_state_nxt = HALT;
                end
            end
            STALL: begin
                if (branch_taken || (r_cnt == '0)) w_state_nxt = RUN;
                else                               w_cnt_nxt   = r_cnt - 1'b1;
            end
            HALT: begin
                if (resume) w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = BOOT;
                w_cnt_nxt   = BOOT_INIT;
            end
        endcase
    end

    // Output decode of current state and inputs
    always_comb begin
        pc_write   = 1'b1;
        writeIFID  = 1'b1;
        PCSrc      = 1'b0;
        jump       = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        case (r_state)
            BOOT: begin
                pc_write   = 1'b0;
                writeIFID  = 1'b0;
                flush_ifid = 1'b1;
            end
            RUN: begin
                if (branch_taken) begin
                    PCSrc      = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (w_hazard) begin
                    pc_write   = 1'b0;
                    writeIFID  = 1'b0;
                    flush_idex = 1'b1;
                end else if (jump_id) begin
                    jump       = 1'b1;
                    flush_ifid = 1'b1;
                end else if (halt_id) begin
                    pc_write   = 1'b0;
                    writeIFID  = 1'b0;
                    flush_ifid = 1'b1;
                end
            end
            STALL: begin
                if (branch_taken) begin
                    PCSrc      = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                    writeIFID  = 1'b0;
                    flush_idex = 1'b1;
                end
            end
            HALT: begin
                pc_write  = 1'b0;
                writeIFID = 1'b0;
                halted    = 1'b1;
            end
            default: begin
                pc_write  = 1'b0;
                writeIFID = 1'b0;
            end
        endcase
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic              w_stall_evt;
    logic              w_flush_evt;

    assign w_stall_evt = !pc_write && ((r_state == RUN) || (r_state == STALL));
    assign w_flush_evt = flush_ifid && (r_state != BOOT);

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (LOAD_STALL 1 and 3) share
// inputs and are checked every cycle against a behavioural model, plus a
// decode table and hand-written multi-cycle sequences.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic [9:0] bt;
        logic       j;
        logic [9:0] jt;
        logic       h;
        logic       rsm;
    } in_t;

    typedef struct packed {
        logic        pc_write;
        logic        writeIFID;
        logic        PCSrc;
        logic [9:0]  PCJump;
        logic        jump;
        logic [9:0]  jumpAdd;
        logic        flush_ifid;
        logic        flush_idex;
        logic        halted;
        logic [15:0] stall_count;
        logic [15:0] flush_count;
    } out_t;

    // expected = {pc_write, writeIFID, PCSrc, jump, flush_ifid, flush_idex}
    typedef struct packed {
        in_t        i;
        logic [5:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic ex_memread = 1'b0, branch_taken = 1'b0, jump_id = 1'b0;
    logic halt_id = 1'b0, resume = 1'b0;
    logic [9:0] branch_target = '0, jump_target = '0;

    logic        pw1, wi1, ps1, jp1, fi1, fx1, ht1;
    logic [9:0]  pj1, ja1;
    logic [15:0] sc1, fc1;
    logic        pw3, wi3, ps3, jp3, fi3, fx3, ht3;
    logic [9:0]  pj3, ja3;
    logic [15:0] sc3, fc3;
    out_t g1, g3;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(10), .REG_W(5), .BOOT_CYCLES(4), .LOAD_STALL(1)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump_id(jump_id), .jump_target(jump_target),
        .halt_id(halt_id), .resume(resume), .pc_write(pw1), .writeIFID(wi1),
        .PCSrc(ps1), .PCJump(pj1), .jump(jp1), .jumpAdd(ja1), .flush_ifid(fi1),
        .flush_idex(fx1), .halted(ht1), .stall_count(sc1), .flush_count(fc1)
    );

    fetch_sequencer #(.PC_W(10), .REG_W(5), .BOOT_CYCLES(4), .LOAD_STALL(3)) dut3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump_id(jump_id), .jump_target(jump_target),
        .halt_id(halt_id), .resume(resume), .pc_write(pw3), .writeIFID(wi3),
        .PCSrc(ps3), .PCJump(pj3), .jump(jp3), .jumpAdd(ja3), .flush_ifid(fi3),
        .flush_idex(fx3), .halted(ht3), .stall_count(sc3), .flush_count(fc3)
    );

    assign g1 = {pw1, wi1, ps1, pj1, jp1, ja1, fi1, fx1, ht1, sc1, fc1};
    assign g3 = {pw3, wi3, ps3, pj3, jp3, ja3, fi3, fx3, ht3, sc3, fc3};

    int n_vec = 0;
    int n_bad = 0;

    // Model: mode 0=boot 1=run 2=stall 3=halt; left = cycles remaining in mode
    int m_mode[2];
    int m_left[2];
    int m_sc[2];
    int m_fc[2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_left[k] = 4; m_sc[k] = 0; m_fc[k] = 0;
        end
    endfunction

    function automatic out_t m_out(input int k);
        out_t o;
        bit hz;
        o = '0;
        o.pc_write = 1'b1;
        o.writeIFID = 1'b1;
        o.PCJump = branch_target;
        o.jumpAdd = jump_target;
`ifdef FETCH_SEQ_PERF_EN
        o.stall_count = 16'(m_sc[k]);
        o.flush_count = 16'(m_fc[k]);
`endif
        hz = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        if (m_mode[k] == 0) begin
            o.pc_write = 0; o.writeIFID = 0; o.flush_ifid = 1;
        end else if (m_mode[k] == 3) begin
            o.pc_write = 0; o.writeIFID = 0; o.halted = 1;
        end else if (branch_taken) begin
            o.PCSrc = 1; o.flush_ifid = 1; o.flush_idex = 1;
        end else if (m_mode[k] == 2 || hz) begin
            o.pc_write = 0; o.writeIFID = 0; o.flush_idex = 1;
        end else if (jump_id) begin
            o.jump = 1; o.flush_ifid = 1;
        end else if (halt_id) begin
            o.pc_write = 0; o.writeIFID = 0; o.flush_ifid = 1;
        end
        return o;
    endfunction

    function automatic void m_step(input int k);
        out_t o;
        bit hz;
        int ls;
        ls = (k == 0) ? 1 : 3;
        o = m_out(k);
        hz = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        if ((m_mode[k] == 1 || m_mode[k] == 2) && !o.pc_write && m_sc[k] < 65535) m_sc[k]++;
        if (m_mode[k] != 0 && o.flush_ifid && m_fc[k] < 65535) m_fc[k]++;
        case (m_mode[k])
            0: begin
                m_left[k]--;
                if (m_left[k] == 0) m_mode[k] = 1;
            end
            1: begin
                if (branch_taken) m_mode[k] = 1;
                else if (hz) begin
                    if (ls > 1) begin m_mode[k] = 2; m_left[k] = ls - 1; end
                end
                else if (jump_id) m_mode[k] = 1;
                else if (halt_id) m_mode[k] = 3;
            end
            2: begin
                if (branch_taken) m_mode[k] = 1;
                else begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_mode[k] = 1;
                end
            end
            default: if (resume) m_mode[k] = 1;
        endcase
    endfunction

    task automatic drive(input in_t v);
        id_rs = v.rs; id_rt = v.rt; ex_memread = v.mr; ex_rt = v.ert;
        branch_taken = v.br; branch_target = v.bt; jump_id = v.j;
        jump_target = v.jt; halt_id = v.h; resume = v.rsm;
    endtask

    task automatic idle_in();
        drive('0);
    endtask

    // One clock: compare both DUTs to the model mid-cycle, then advance
    task automatic cycle();
        @(negedge clk);
        chk("dut1_vs_model", 64'(g1), 64'(m_out(0)));
        chk("dut3_vs_model", 64'(g3), 64'(m_out(1)));
        if (reset) m_reset();
        else begin m_step(0); m_step(1); end
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                               input logic [4:0] ert, input logic br, input logic [9:0] bt,
                               input logic j, input logic [9:0] jt);
        in_t v;
        v = '0;
        v.rs = rs; v.rt = rt; v.mr = mr; v.ert = ert;
        v.br = br; v.bt = bt; v.j = j; v.jt = jt;
        return v;
    endfunction

    vec_t tab[11];

    initial begin
        // RUN-state decode table for the LOAD_STALL=1 instance
        tab[0]  = '{mk(5'd1, 5'd2, 0, 5'd0,  0, 10'h000, 0, 10'h000), 6'b110000};
        tab[1]  = '{mk(5'd8, 5'd3, 1, 5'd8,  0, 10'h000, 0, 10'h000), 6'b000001};
        tab[2]  = '{mk(5'd3, 5'd8, 1, 5'd8,  0, 10'h000, 0, 10'h000), 6'b000001};
        tab[3]  = '{mk(5'd0, 5'd0, 1, 5'd0,  0, 10'h000, 0, 10'h000), 6'b110000};
        tab[4]  = '{mk(5'd8, 5'd8, 0, 5'd8,  0, 10'h000, 0, 10'h000), 6'b110000};
        tab[5]  = '{mk(5'd8, 5'd9, 1, 5'd24, 0, 10'h000, 0, 10'h000), 6'b110000};
        tab[6]  = '{mk(5'd1, 5'd2, 0, 5'd0,  0, 10'h000, 1, 10'h002), 6'b110110};
        tab[7]  = '{mk(5'd1, 5'd2, 0, 5'd0,  1, 10'h02A, 1, 10'h002), 6'b111011};
        tab[8]  = '{mk(5'd8, 5'd2, 1, 5'd8,  1, 10'h155, 0, 10'h000), 6'b111011};
        tab[9]  = '{mk(5'd5, 5'd31, 1, 5'd31, 0, 10'h000, 1, 10'h3FF), 6'b000001};
        tab[10] = '{mk(5'd1, 5'd2, 0, 5'd0,  1, 10'h3FF, 0, 10'h000), 6'b111011};

        m_reset();
        idle_in();
        #1;
        chk("reset_pc_write", 64'(pw1), 64'd0);
        chk("reset_flush_ifid", 64'(fi1), 64'd1);
        chk("reset_counters", 64'({sc1, fc1}), 64'd0);
        cycle(); cycle();
        reset = 1'b0;

        // Boot hold: exactly 4 cycles, then fetch resumes
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("boot_hold", 64'({pw1, wi1, fi1}), 64'b001);
            @(posedge clk); #1;
            m_step(0); m_step(1);
        end
        @(negedge clk);
        chk("boot_done_pc_write", 64'(pw1), 64'd1);
        @(posedge clk); #1;
        m_step(0); m_step(1);

        // Decode table
        for (int t = 0; t < 11; t++) begin
            drive(tab[t].i);
            @(negedge clk);
            chk($sformatf("table_%0d", t), 64'({pw1, wi1, ps1, jp1, fi1, fx1}), 64'(tab[t].e));
            chk($sformatf("table_%0d_addr", t), 64'({pj1, ja1}), 64'({tab[t].i.bt, tab[t].i.jt}));
            @(posedge clk); #1;
            m_step(0); m_step(1);
        end
        idle_in();
        cycle(); cycle(); cycle();

        // LOAD_STALL=3: branch in the 2nd stall cycle aborts the stall
        drive(mk(5'd8, 5'd0, 1, 5'd8, 0, 10'h000, 0, 10'h000));
        cycle();
        idle_in();
        @(negedge clk);
        chk("stall3_cycle1", 64'({pw3, wi3, fx3}), 64'b001);
        @(posedge clk); #1;
        m_step(0); m_step(1);
        branch_taken = 1'b1; branch_target = 10'h2A;
        @(negedge clk);
        chk("stall3_branch", 64'({ps3, pj3, fi3, fx3, pw3}), 64'({1'b1, 10'h2A, 1'b1, 1'b1, 1'b1}));
        @(posedge clk); #1;
        m_step(0); m_step(1);
        idle_in();
        @(negedge clk);
        chk("stall3_run_after", 64'({pw3, fx3}), 64'b10);
        @(posedge clk); #1;
        m_step(0); m_step(1);

        // Halt held for 20 cycles with branch noise, then resume
        halt_id = 1'b1;
        cycle();
        halt_id = 1'b0;
        for (int c = 0; c < 20; c++) begin
            branch_taken = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("halt_hold", 64'({ht1, pw1, ps1, ht3}), 64'b1001);
            @(posedge clk); #1;
            m_step(0); m_step(1);
        end
        branch_taken = 1'b0;
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        @(negedge clk);
        chk("resume_run", 64'({ht1, pw1}), 64'b01);
        @(posedge clk); #1;
        m_step(0); m_step(1);

        // Reset while halted returns to BOOT without waiting for a clock
        halt_id = 1'b1;
        cycle();
        halt_id = 1'b0;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("reset_in_halt", 64'({ht1, pw1, fi1, ht3}), 64'b0010);
        m_reset();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) cycle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            ex_memread = ($urandom_range(0, 1) == 1);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_target = 10'($urandom);
            jump_id = ($urandom_range(0, 7) == 0);
            jump_target = 10'($urandom);
            halt_id = ($urandom_range(0, 15) == 0);
            resume = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if (reset) m_reset();
            cycle();
        end
        reset = 1'b0;
        idle_in();

`ifdef FETCH_SEQ_PERF_EN
        // 3 load-use hazards and 2 branches on a fresh run
        reset = 1'b1;
        #1;
        m_reset();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        for (int h = 0; h < 3; h++) begin
            drive(mk(5'd8, 5'd0, 1, 5'd8, 0, 10'h000, 0, 10'h000));
            cycle();
            idle_in();
            cycle(); cycle();
        end
        for (int b = 0; b < 2; b++) begin
            branch_taken = 1'b1;
            cycle();
            idle_in();
            cycle();
        end
        #1;
        chk("perf_stall3", 64'(sc1), 64'd3);
        chk("perf_flush2", 64'(fc1), 64'd2);
        // Saturation
        drive(mk(5'd8, 5'd0, 1, 5'd8, 0, 10'h000, 0, 10'h000));
        for (int c = 0; c < 70000; c++) cycle();
        idle_in();
        #1;
        chk("perf_stall_sat", 64'(sc1), 64'hFFFF);
`else
        #1;
        chk("counters_tied_off", 64'({sc1, fc1, sc3, fc3}), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block that drives the InstructionFetch stage of the 5-stage MIPS pipeline.
- Generates PC write enable, IF/ID write enable, redirect selects and targets (branch via PCJump/PCSrc, jump via jumpAdd/jump), and pipeline flush/bubble requests.
- Sequences boot hold, load-use stalls, branch/jump redirects and halt/resume.

Parameters:
- PC_W, 10, PC/address width (matches PCJump/jumpAdd).
- REG_W, 5, register specifier width.
- BOOT_CYCLES, 4, cycles PC is held after reset release (range 1..15).
- LOAD_STALL, 1, bubble cycles per load-use hazard (range 1..3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  destination of the load in EX.
- branch_taken  in  1  branch resolved taken, EX/MEM.
- branch_target  in  PC_W  resolved branch address.
- jump_id  in  1  J-type instruction decoded in ID.
- jump_target  in  PC_W  decoded jump address.
- halt_id  in  1  halt instruction decoded in ID.
- resume  in  1  one-cycle pulse that leaves HALT.
- pc_write  out  1  PC register enable.
- writeIFID  out  1  IF/ID register enable.
- PCSrc  out  1  1 = next PC is PCJump.
- PCJump  out  PC_W  branch redirect address.
- jump  out  1  1 = next PC is jumpAdd.
- jumpAdd  out  PC_W  jump redirect address.
- flush_ifid  out  1  squash IF/ID contents.
- flush_idex  out  1  insert bubble into ID/EX.
- halted  out  1  state == HALT.
- stall_count, flush_count  out  16  performance counters.

Behaviour:
- Interface: single clock clk; reset is asynchronous, active-high.
- State is registered. Outputs are combinational decodes of state and inputs.
- PCJump = branch_target and jumpAdd = jump_target at all times; only the selects are gated.
- Defaults: pc_write = 1, writeIFID = 1, all other outputs 0.
- States: BOOT, RUN, STALL, HALT. Down-counter cnt is 4 bits.
- Reset (async): state = BOOT, cnt = BOOT_CYCLES-1, counters = 0. Outputs follow the BOOT decode.
- Reset asserted mid-operation aborts any stall, halt or redirect immediately.
- BOOT:
  - pc_write = 0, writeIFID = 0, flush_ifid = 1; all redirect inputs ignored.
  - cnt decrements each cycle. At cnt == 0, next state is RUN.
- RUN, checks in fixed priority (highest first):
  1. branch_taken: PCSrc = 1, flush_ifid = 1, flush_idex = 1. Overrides all lower conditions. State stays RUN.
  2. Load-use, defined as ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt):
     - pc_write = 0, writeIFID = 0, flush_idex = 1.
     - If LOAD_STALL > 1: go to STALL with cnt = LOAD_STALL-2. Otherwise stay in RUN.
     - jump_id and halt_id are ignored this cycle; they are re-evaluated after the stall.
  3. jump_id: jump = 1, flush_ifid = 1.
  4. halt_id: pc_write = 0, writeIFID = 0, flush_ifid = 1. Go to HALT.
- STALL:
  - pc_write = 0, writeIFID = 0, flush_idex = 1.
  - At cnt == 0 return to RUN; otherwise decrement cnt.
  - branch_taken in STALL: apply the RUN branch response, abort the stall, go to RUN.
- HALT:
  - pc_write = 0, writeIFID = 0, halted = 1.
  - On resume: go to RUN with no other effect.
  - branch_taken is ignored in HALT; the pipeline is drained before a halt can be reached.
- Width rules: register compare is exact REG_W bits. Register 0 never creates a hazard.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- With the macro:
  - stall_count increments each cycle pc_write == 0 in RUN or STALL.
  - flush_count increments each cycle flush_ifid == 1 outside BOOT.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by reset.
- Without the macro: both counter ports are tied to 0 and no counter flops exist.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum (BOOT, RUN, STALL, HALT);
  - PC_W and REG_W defaults;
  - the counter width constant.
- One natural sub-module: load_use_detect, a pure combinational hazard compare (id_rs, id_rt, ex_memread, ex_rt -> hazard).
- The FSM stays in the top module.

Test Plan:
- Reset, then release with BOOT_CYCLES = 4 → pc_write = writeIFID = 0 and flush_ifid = 1 for exactly 4 cycles; pc_write = 1 on the 5th.
- RUN with ex_memread = 1, ex_rt = 8, id_rs = 8 → one cycle of pc_write = 0, writeIFID = 0, flush_idex = 1. Repeat with ex_rt = 0 → no stall.
- LOAD_STALL = 3, hazard, then branch_taken = 1 and branch_target = 10'h2A in the 2nd stall cycle → PCSrc = 1, PCJump = 0x2A, both flushes asserted, state RUN next cycle.
- jump_id = 1, jump_target = 2 in RUN → jump = 1, jumpAdd = 2, flush_ifid = 1 for one cycle. Same cycle with branch_taken = 1 → only PCSrc = 1, jump = 0.
- halt_id = 1 → halted = 1 and pc_write = 0 held for 20 cycles; resume pulse → RUN next cycle. Assert reset while halted → BOOT immediately.
- With FETCH_SEQ_PERF_EN: 3 load-use hazards plus 2 branches → stall_count = 3, flush_count = 2. Force 70000 stall cycles → stall_count holds at 0xFFFF.
